// File: rtl/frame_sequencer.sv
// frame_sequencer: arms a single camera-frame capture into the frame buffer,
// runs the image processor over whole VGA frames until both results are ready,
// then hands the result to the serial reporter. All outputs are registered.
module frame_sequencer #(
    parameter int SKIP_FRAMES     = 1,
    parameter int MAX_PROC_FRAMES = 4,
    parameter int CAM_TIMEOUT     = 2000000,
    parameter int CNT_W           = 22
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       CONTINUOUS,
    input  logic       CAM_VSYNC,
    input  logic       VGA_VSYNC_NEG,
    input  logic       COLOR_DONE,
    input  logic       SHAPE_DONE,
    input  logic       SER_BUSY,
    output logic       W_GATE,
    output logic       PROC_EN,
    output logic       PROC_CLEAR,
    output logic       SER_START,
    output logic [2:0] STATE,
    output logic [7:0] FRAME_COUNT,
    output logic [1:0] ERR,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SYNC        = 3'd1,
        S_CAPTURE     = 3'd2,
        S_WAIT_VGA    = 3'd3,
        S_PROCESS     = 3'd4,
        S_REPORT_REQ  = 3'd5,
        S_REPORT_WAIT = 3'd6,
        S_ILLEGAL     = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] CAM_LAST = CNT_W'(CAM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       SKIP_LD  = 8'(SKIP_FRAMES);
    localparam logic [7:0]       FRM_MAX  = 8'(MAX_PROC_FRAMES);

    state_t           state_q, state_d;
    logic [7:0]       skip_q, skip_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       frm_q, frm_d;
    logic [7:0]       fcount_q, fcount_d;
    logic [1:0]       err_q, err_d;
    logic             color_q, color_d, shape_q, shape_d, seen_q, seen_d;
    logic             proc_clear_q, proc_clear_d, ser_start_q, ser_start_d;
    logic             w_gate_q, proc_en_q, busy_q;
    logic             cam_prev_q, vga_prev_q, cam_sof_q, cam_eof_q, vga_sof_q;
    logic             cam_edge, cam_tmo, rpt_done;

    // Sync-edge detection; pulses are registered so an edge acts one cycle after the input moves
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cam_prev_q <= 1'b0;
            vga_prev_q <= 1'b1;
            cam_sof_q  <= 1'b0;
            cam_eof_q  <= 1'b0;
            vga_sof_q  <= 1'b0;
        end else begin
            cam_prev_q <= CAM_VSYNC;
            vga_prev_q <= VGA_VSYNC_NEG;
            cam_sof_q  <= cam_prev_q & ~CAM_VSYNC;
            cam_eof_q  <= ~cam_prev_q & CAM_VSYNC;
            vga_sof_q  <= vga_prev_q & ~VGA_VSYNC_NEG;
        end
    end

    assign cam_edge = cam_sof_q | cam_eof_q;
    assign cam_tmo  = (cnt_q == CAM_LAST);

    // Next-state and datapath updates for the capture/process/report sequence
    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        cnt_d        = cnt_q;
        frm_d        = frm_q;
        fcount_d     = fcount_q;
        err_d        = err_q;
        color_d      = color_q;
        shape_d      = shape_q;
        seen_d       = seen_q;
        proc_clear_d = 1'b0;
        ser_start_d  = 1'b0;
        rpt_done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_SYNC;
                    skip_d  = SKIP_LD;
                    cnt_d   = '0;
                end
            end
            S_SYNC: begin
                cnt_d = cam_edge ? '0 : cnt_q + CNT_ONE;
                if (cam_sof_q && skip_q == 8'd0) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else if (cam_sof_q) begin
                    skip_d = skip_q - 8'd1;
                end else if (!cam_edge && cam_tmo) begin
                    err_d[0] = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_CAPTURE: begin
                cnt_d = cam_edge ? '0 : cnt_q + CNT_ONE;
                if (cam_eof_q) begin
                    state_d = S_WAIT_VGA;
                end else if (!cam_edge && cam_tmo) begin
                    err_d[0] = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_WAIT_VGA: begin
                if (vga_sof_q) begin
                    state_d      = S_PROCESS;
                    proc_clear_d = 1'b1;
                    frm_d        = 8'd0;
                    // a done pulse coincident with entry must not be lost
                    color_d      = COLOR_DONE;
                    shape_d      = SHAPE_DONE;
                end
            end
            S_PROCESS: begin
                color_d = color_q | COLOR_DONE;
                shape_d = shape_q | SHAPE_DONE;
                // completion is checked first so it beats a coincident frame timeout
                if (color_q && shape_q) begin
                    state_d = S_REPORT_REQ;
                end else if (vga_sof_q) begin
                    frm_d = frm_q + 8'd1;
                    if (frm_q + 8'd1 == FRM_MAX) begin
                        err_d[1] = 1'b1;
                        state_d  = S_REPORT_REQ;
                    end
                end
            end
            S_REPORT_REQ: begin
                if (!SER_BUSY) begin
                    ser_start_d = 1'b1;
                    state_d     = S_REPORT_WAIT;
                    seen_d      = 1'b0;
                    cnt_d       = '0;
                end
            end
            S_REPORT_WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (!seen_q) begin
                    if (SER_BUSY) seen_d = 1'b1;
                    else if (cam_tmo) rpt_done = 1'b1;   // link never answered
                end else if (!SER_BUSY) begin
                    rpt_done = 1'b1;
                end
                if (rpt_done) begin
                    fcount_d = fcount_q + 8'd1;
                    if (CONTINUOUS) begin
                        state_d = S_SYNC;
                        skip_d  = SKIP_LD;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; gate/enable/busy are decoded from the next state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            skip_q       <= 8'd0;
            cnt_q        <= '0;
            frm_q        <= 8'd0;
            fcount_q     <= 8'd0;
            err_q        <= 2'b00;
            color_q      <= 1'b0;
            shape_q      <= 1'b0;
            seen_q       <= 1'b0;
            proc_clear_q <= 1'b0;
            ser_start_q  <= 1'b0;
            w_gate_q     <= 1'b0;
            proc_en_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            cnt_q        <= cnt_d;
            frm_q        <= frm_d;
            fcount_q     <= fcount_d;
            err_q        <= err_d;
            color_q      <= color_d;
            shape_q      <= shape_d;
            seen_q       <= seen_d;
            proc_clear_q <= proc_clear_d;
            ser_start_q  <= ser_start_d;
            w_gate_q     <= (state_d == S_CAPTURE);
            proc_en_q    <= (state_d == S_PROCESS);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign W_GATE      = w_gate_q;
    assign PROC_EN     = proc_en_q;
    assign PROC_CLEAR  = proc_clear_q;
    assign SER_START   = ser_start_q;
    assign STATE       = state_q;
    assign FRAME_COUNT = fcount_q;
    assign ERR         = err_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed stimulus with a report scoreboard. Expected
// report contents are queued when a processing run is started and checked
// when the DUT raises SER_START. A second instance covers the camera timeout.
module tb_frame_sequencer;

    localparam int HI_CYC = 10;
    localparam int LO_CYC = 500;

    logic       CLK, RESET, START, CONTINUOUS, CAM_VSYNC, VGA_VSYNC_NEG;
    logic       COLOR_DONE, SHAPE_DONE, SER_BUSY;
    logic       W_GATE, PROC_EN, PROC_CLEAR, SER_START, BUSY;
    logic [2:0] STATE;
    logic [7:0] FRAME_COUNT;
    logic [1:0] ERR;

    logic       t_start;
    logic       t_wg, t_pen, t_pclr, t_ss, t_busy;
    logic [2:0] t_state;
    logic [7:0] t_fc;
    logic [1:0] t_err;

    typedef struct {
        logic       err1;
        logic [7:0] fc;
    } rpt_t;

    rpt_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_ser = 0;
    int   hi_cnt;

    frame_sequencer #(
        .SKIP_FRAMES(1), .MAX_PROC_FRAMES(4), .CAM_TIMEOUT(1000), .CNT_W(22)
    ) u_dut (
        .CLK(CLK), .RESET(RESET), .START(START), .CONTINUOUS(CONTINUOUS),
        .CAM_VSYNC(CAM_VSYNC), .VGA_VSYNC_NEG(VGA_VSYNC_NEG),
        .COLOR_DONE(COLOR_DONE), .SHAPE_DONE(SHAPE_DONE), .SER_BUSY(SER_BUSY),
        .W_GATE(W_GATE), .PROC_EN(PROC_EN), .PROC_CLEAR(PROC_CLEAR),
        .SER_START(SER_START), .STATE(STATE), .FRAME_COUNT(FRAME_COUNT),
        .ERR(ERR), .BUSY(BUSY)
    );

    // short-timeout instance, camera held still
    frame_sequencer #(
        .SKIP_FRAMES(1), .MAX_PROC_FRAMES(4), .CAM_TIMEOUT(100), .CNT_W(22)
    ) u_dut_to (
        .CLK(CLK), .RESET(RESET), .START(t_start), .CONTINUOUS(1'b0),
        .CAM_VSYNC(1'b0), .VGA_VSYNC_NEG(1'b1),
        .COLOR_DONE(1'b0), .SHAPE_DONE(1'b0), .SER_BUSY(1'b0),
        .W_GATE(t_wg), .PROC_EN(t_pen), .PROC_CLEAR(t_pclr),
        .SER_START(t_ss), .STATE(t_state), .FRAME_COUNT(t_fc),
        .ERR(t_err), .BUSY(t_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic arm();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    // one skipped frame, one captured frame, then the closing VSYNC rise
    task automatic capture_frame();
        CAM_VSYNC = 1'b1; repeat (HI_CYC) step();
        CAM_VSYNC = 1'b0; repeat (LO_CYC) step();
        CAM_VSYNC = 1'b1; repeat (HI_CYC) step();
        CAM_VSYNC = 1'b0; repeat (LO_CYC) step();
        CAM_VSYNC = 1'b1; repeat (2) step();
    endtask

    task automatic vga_fall();
        VGA_VSYNC_NEG = 1'b1; repeat (8) step();
        VGA_VSYNC_NEG = 1'b0; repeat (2) step();
    endtask

    task automatic report_handshake();
        SER_BUSY = 1'b1; repeat (20) step();
        SER_BUSY = 1'b0; step();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while (STATE !== s && n < budget) begin
            step();
            n++;
        end
        chk("wait_state", STATE, s);
    endtask

    // scoreboard: each SER_START must match the oldest queued expectation
    always @(negedge CLK) begin : sb_mon
        rpt_t e;
        if (SER_START === 1'b1) begin
            n_ser++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rpt_err1", ERR[1], e.err1);
                chk("rpt_fc", FRAME_COUNT, e.fc);
            end
        end
    end

    initial begin
        RESET = 1'b1; START = 1'b0; CONTINUOUS = 1'b0; CAM_VSYNC = 1'b1;
        VGA_VSYNC_NEG = 1'b1; COLOR_DONE = 1'b0; SHAPE_DONE = 1'b0;
        SER_BUSY = 1'b0; t_start = 1'b0;
        repeat (3) step();
        chk("rst_state", STATE, 3'd0);
        chk("rst_wgate", W_GATE, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_err", ERR, 2'd0);
        chk("rst_fc", FRAME_COUNT, 8'd0);
        chk("rst_pen", PROC_EN, 1'b0);
        RESET = 1'b0;
        step();

        // capture: skip one frame, gate exactly the next one
        arm();
        chk("arm_state", STATE, 3'd1);
        chk("arm_busy", BUSY, 1'b1);
        repeat (HI_CYC) step();
        CAM_VSYNC = 1'b0; repeat (2) step();
        chk("skip_wgate", W_GATE, 1'b0);
        chk("skip_state", STATE, 3'd1);
        repeat (LO_CYC - 2) step();
        CAM_VSYNC = 1'b1; repeat (HI_CYC) step();
        CAM_VSYNC = 1'b0;
        step(); chk("cap_wg_1", W_GATE, 1'b0);
        step(); chk("cap_wg_2", W_GATE, 1'b1);
        chk("cap_state", STATE, 3'd2);
        hi_cnt = 1;
        repeat (LO_CYC - 2) begin
            step();
            if (W_GATE) hi_cnt++;
        end
        CAM_VSYNC = 1'b1;
        step(); chk("eof_wg_1", W_GATE, 1'b1);
        if (W_GATE) hi_cnt++;
        step(); chk("eof_wg_2", W_GATE, 1'b0);
        chk("wait_vga_state", STATE, 3'd3);
        chk("wgate_width", hi_cnt, LO_CYC);

        // process: color at frame 1, shape at frame 2
        sb_q.push_back('{1'b0, 8'd0});
        vga_fall();
        chk("pclr_on", PROC_CLEAR, 1'b1);
        chk("pen_on", PROC_EN, 1'b1);
        chk("proc_state", STATE, 3'd4);
        step(); chk("pclr_off", PROC_CLEAR, 1'b0);
        vga_fall();
        COLOR_DONE = 1'b1; step(); COLOR_DONE = 1'b0;
        vga_fall();
        SHAPE_DONE = 1'b1; step(); SHAPE_DONE = 1'b0;
        chk("pen_hold", PROC_EN, 1'b1);
        step();
        chk("pen_drop", PROC_EN, 1'b0);
        chk("req_state", STATE, 3'd5);
        chk("err1_clr", ERR[1], 1'b0);
        step();
        chk("ser_start", SER_START, 1'b1);
        chk("rw_state", STATE, 3'd6);
        step(); chk("ser_start_1cyc", SER_START, 1'b0);
        report_handshake();
        chk("fc1", FRAME_COUNT, 8'd1);
        chk("idle_state", STATE, 3'd0);

        // processing timeout: no done pulses
        arm();
        capture_frame();
        chk("t4_wait", STATE, 3'd3);
        sb_q.push_back('{1'b1, 8'd1});
        vga_fall();
        chk("t4_proc", STATE, 3'd4);
        repeat (3) vga_fall();
        chk("t4_frame3", STATE, 3'd4);
        chk("t4_err_pre", ERR[1], 1'b0);
        vga_fall();
        chk("t4_tmo_state", STATE, 3'd5);
        chk("t4_err1", ERR[1], 1'b1);
        chk("t4_pen", PROC_EN, 1'b0);
        wait_state(3'd6, 5);
        report_handshake();
        chk("fc2", FRAME_COUNT, 8'd2);

        // camera timeout on the short-timeout instance
        t_start = 1'b1; step(); t_start = 1'b0;
        chk("to_arm", t_state, 3'd1);
        repeat (99) step();
        chk("to_state_100", t_state, 3'd1);
        chk("to_err_100", t_err[0], 1'b0);
        chk("to_busy_100", t_busy, 1'b1);
        chk("to_wg_100", t_wg, 1'b0);
        step();
        chk("to_state_101", t_state, 3'd0);
        chk("to_err0", t_err[0], 1'b1);
        chk("to_busy_101", t_busy, 1'b0);

        // reset in the middle of a capture; ERR survived the earlier START
        arm();
        CAM_VSYNC = 1'b1; repeat (HI_CYC) step();
        CAM_VSYNC = 1'b0; repeat (LO_CYC) step();
        CAM_VSYNC = 1'b1; repeat (HI_CYC) step();
        CAM_VSYNC = 1'b0; repeat (10) step();
        chk("pre_rst_state", STATE, 3'd2);
        chk("pre_rst_err", ERR, 2'd2);
        RESET = 1'b1;
        step();
        chk("mrst_wgate", W_GATE, 1'b0);
        chk("mrst_state", STATE, 3'd0);
        chk("mrst_err", ERR, 2'd0);
        chk("mrst_fc", FRAME_COUNT, 8'd0);
        chk("mrst_busy", BUSY, 1'b0);
        repeat (2) step();
        RESET = 1'b0;
        CAM_VSYNC = 1'b1;
        step();

        // continuous mode: three back-to-back report cycles, START ignored while busy
        CONTINUOUS = 1'b1;
        arm();
        for (int i = 0; i < 3; i++) begin
            capture_frame();
            chk("c_wait", STATE, 3'd3);
            sb_q.push_back('{1'b0, 8'(i)});
            vga_fall();
            START = 1'b1; COLOR_DONE = 1'b1; SHAPE_DONE = 1'b1;
            step();
            START = 1'b0; COLOR_DONE = 1'b0; SHAPE_DONE = 1'b0;
            chk("c_start_ign", STATE, 3'd4);
            wait_state(3'd6, 10);
            report_handshake();
            chk("c_resync", STATE, 3'd1);
            chk("c_fc", FRAME_COUNT, 8'(i + 1));
        end
        CONTINUOUS = 1'b0;
        step();

        chk("sb_drain", sb_q.size(), 0);
        chk("ser_pulses", n_ser, 5);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
